// File: rtl/sync_sequencer.sv
// Per-frame scheduler for the PPU sync writers: pulses each enabled
// channel in index order, hands it the source-RAM port, and aborts it if it hangs.
module sync_sequencer #(
  parameter int NUM_CHAN       = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_WIDTH       = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vblank_start,
  input  logic [NUM_CHAN-1:0]  chan_en,
  output logic [NUM_CHAN-1:0]  sync,
  input  logic [NUM_CHAN-1:0]  done,
  output logic [SEL_WIDTH-1:0] src_sel,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timeout_err,
  output logic                 overrun_err,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_e;

  localparam logic [TO_WIDTH-1:0] WD_MAX =
    TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [NUM_CHAN-1:0]  pend_q, pend_d;
  logic [SEL_WIDTH-1:0] cur_q, cur_d;
  logic [TO_WIDTH-1:0]  wd_q, wd_d;
  logic                 to_q, to_d;
  logic                 ov_q, ov_d;

  logic [NUM_CHAN-1:0]  cur_oh;
  logic [NUM_CHAN-1:0]  rest;
  logic                 cur_done;
  logic                 wd_hit;
  logic                 to_set;
  logic                 ov_set;

  function automatic logic [SEL_WIDTH-1:0] lowest(
    input logic [NUM_CHAN-1:0] m
  );
    logic [SEL_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (m[i]) idx = SEL_WIDTH'(i);
    end
    return idx;
  endfunction

  assign cur_oh   = NUM_CHAN'(1) << cur_q;
  assign rest     = pend_q & ~cur_oh;
  assign cur_done = done[cur_q];
  assign wd_hit   = (wd_q == WD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      cur_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    wd_d    = wd_q;
    to_set  = 1'b0;
    ov_set  = vblank_start && (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (vblank_start) begin
          pend_d = chan_en;
          if (|chan_en) begin
            cur_d   = lowest(chan_en);
            state_d = S_ISSUE;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + TO_WIDTH'(1);
        // a timed-out channel is retired exactly like a finished one
        if (cur_done || wd_hit) begin
          to_set = !cur_done;
          pend_d = rest;
          if (|rest) begin
            cur_d   = lowest(rest);
            state_d = S_ISSUE;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // set beats a simultaneous clear
    to_d = (to_q && !err_clr) || to_set;
    ov_d = (ov_q && !err_clr) || ov_set;
  end

  always_comb begin
    sync        = (state_q == S_ISSUE) ? cur_oh : '0;
    busy        = (state_q != S_IDLE);
    frame_done  = (state_q == S_FINISH);
    src_sel     = cur_q;
    timeout_err = to_q;
    overrun_err = ov_q;
  end

endmodule
